// File: rtl/cdc_fifo_wr_ctrl_hyper.sv
// Write-side control of the dual-clock FIFO: owns the write pointer, publishes it in Gray code, and derives fill/full from the synchronized read pointer.
// A write lands on the accepting edge; read-pointer moves reach fill_o SYNC_STAGES-1 edges after the first sampling edge; ready_o drops while full.
module cdc_fifo_wr_ctrl_hyper #(
  parameter int LOG_DEPTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 wr_en_o,
  output logic [LOG_DEPTH-1:0] wr_addr_o,
  output logic [LOG_DEPTH:0]   wptr_gray_o,
  input  logic [LOG_DEPTH:0]   rptr_gray_async_i,
  output logic [LOG_DEPTH:0]   fill_o
);

  localparam int PW = LOG_DEPTH + 1;
  localparam logic [LOG_DEPTH:0] DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};
  localparam logic [LOG_DEPTH:0] ONE   = {{LOG_DEPTH{1'b0}}, 1'b1};

  logic [LOG_DEPTH:0]                  wptr_bin_q, wptr_bin_d;
  logic [LOG_DEPTH:0]                  wptr_gray_q, wptr_gray_d;
  logic [SYNC_STAGES-1:0][LOG_DEPTH:0] rptr_sync_q;
  logic [LOG_DEPTH:0]                  rptr_gray_sync;
  logic [LOG_DEPTH:0]                  rptr_bin_sync;
  logic [LOG_DEPTH:0]                  fill;
  logic                                full;

  // Stage 0 may go metastable; only the last stage is ever decoded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_sync_q <= '0;
    end else begin
      rptr_sync_q <= {rptr_sync_q[SYNC_STAGES-2:0], rptr_gray_async_i};
    end
  end

  assign rptr_gray_sync = rptr_sync_q[SYNC_STAGES-1];

  always_comb begin
    rptr_bin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rptr_bin_sync[i] = ^(rptr_gray_sync >> i);
    end
  end

  // The extra pointer MSB keeps a full FIFO distinct from an empty one.
  assign fill    = wptr_bin_q - rptr_bin_sync;
  assign full    = (fill == DEPTH);
  assign ready_o = ~full;
  assign wr_en_o = valid_i & ready_o & ~rst_i;

  assign wptr_bin_d  = wr_en_o ? (wptr_bin_q + ONE) : wptr_bin_q;
  assign wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
    end
  end

  assign wr_addr_o   = wptr_bin_q[LOG_DEPTH-1:0];
  assign wptr_gray_o = wptr_gray_q;
  assign fill_o      = fill;

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl_hyper.sv
// Bench for the FIFO write controller: directed reset/fill/drain/wrap/simultaneous cases, then an asynchronous reader with a data scoreboard.
module tb_cdc_fifo_wr_ctrl_hyper;

  logic       clk = 1'b0;
  logic       rclk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       ready_o;
  logic       wr_en_o;
  logic [2:0] wr_addr_o;
  logic [3:0] wptr_gray_o;
  logic [3:0] fill_o;
  logic [3:0] rptr_gray;

  logic [3:0] dir_rgray = 4'd0;
  logic [3:0] rd_gray = 4'd0;
  logic       async_mode = 1'b0;
  int         rhalf = 7;

  int checks = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  int         rd_q[$];
  int         mem[8];
  int unsigned pcount = 0;
  int         acc = 0;
  int         npulses = 0;
  int         wcount = 0;
  int         rcount = 0;
  logic [3:0] rbin = 4'd0;
  logic [3:0] rs1 = 4'd0;
  logic [3:0] rs2 = 4'd0;

  assign rptr_gray = async_mode ? rd_gray : dir_rgray;

  cdc_fifo_wr_ctrl_hyper #(.LOG_DEPTH(3), .SYNC_STAGES(2)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .wr_en_o           (wr_en_o),
    .wr_addr_o         (wr_addr_o),
    .wptr_gray_o       (wptr_gray_o),
    .rptr_gray_async_i (rptr_gray),
    .fill_o            (fill_o)
  );

  always #5 clk = ~clk;
  always #(rhalf) rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle; an accepted word's expected address is queued at drive time.
  task automatic step(input logic v);
    valid_i = v;
    if (v && ready_o) begin
      exp_q.push_back(3'(pcount));
      pcount++;
      acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // Write-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      wcount = 0;
    end else begin
      if (async_mode) begin
        check("fill_le_depth", 32'(fill_o <= 4'd8), 32'd1);
        // Stale read pointer can only over-report occupancy.
        check("fill_ge_occ", 32'(int'(fill_o) >= (wcount - rcount)), 32'd1);
      end
      if (wr_en_o) begin
        npulses++;
        if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr", 32'(wr_addr_o), 32'(exp_q.pop_front()));
        if (async_mode) begin
          mem[wr_addr_o] = wcount;
          rd_q.push_back(wcount);
        end
        wcount++;
      end
    end
  end

  // Read-domain consumer model with its own two-flop sync of the Gray write pointer.
  always @(posedge rclk) begin
    if (rst || !async_mode) begin
      rs1 = 4'd0; rs2 = 4'd0; rbin = 4'd0; rd_gray = 4'd0; rcount = 0;
    end else begin
      rs2 = rs1;
      rs1 = wptr_gray_o;
      if (g2b(rs2) != rbin && $urandom_range(0, 3) != 0) begin
        if (rd_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
        else check("rd_data", 32'(mem[rbin[2:0]]), 32'(rd_q.pop_front()));
        rbin = rbin + 4'd1;
        rd_gray = rbin ^ (rbin >> 1);
        rcount++;
      end
    end
  end

  task automatic run_async(input int half, input int words);
    rst = 1'b1;
    valid_i = 1'b0;
    rhalf = half;
    async_mode = 1'b1;
    exp_q.delete();
    rd_q.delete();
    pcount = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 20000 && pcount < words; c++) step($urandom_range(0, 9) < 7);
    valid_i = 1'b0;
    for (int c = 0; c < 400 && rcount < int'(pcount); c++) @(posedge clk);
    #1;
    check("rand_words", pcount, 32'(words));
    check("rand_drain", 32'(rcount), pcount);
    repeat (4) @(posedge clk);
    #1;
    check("rand_final_fill", 32'(fill_o), 32'd0);
    check("rand_expq_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev, cur;
    logic       wrap_seen;
    int         dbin, tgt, ph0, ph1, a0;
    logic [3:0] db4;

    // Power-on reset with valid asserted: must be ignored.
    rst = 1'b1;
    valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_addr", 32'(wr_addr_o), 32'd0);
    check("rst_gray", 32'(wptr_gray_o), 32'd0);
    check("rst_fill", 32'(fill_o), 32'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill: 10 cycles of valid, exactly 8 accepted.
    npulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1);
      check("fill_level", 32'(fill_o), 32'((c + 1 > 8) ? 8 : c + 1));
    end
    check("fill_pulses", 32'(npulses), 32'd8);
    check("fill_ready", 32'(ready_o), 32'd0);
    check("fill_wr_en_blocked", 32'(wr_en_o), 32'd0);
    check("fill_gray", 32'(wptr_gray_o), 32'hC);

    // Drain visibility: one read seen two edges later.
    valid_i = 1'b0;
    dir_rgray = 4'b0001;
    @(posedge clk);
    #1;
    check("drain_lag_fill", 32'(fill_o), 32'd8);
    check("drain_lag_ready", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("drain_fill", 32'(fill_o), 32'd7);
    check("drain_ready", 32'(ready_o), 32'd1);
    check("drain_addr", 32'(wr_addr_o), 32'd0);
    step(1'b1);
    valid_i = 1'b0;
    check("drain_refill", 32'(fill_o), 32'd8);
    check("drain_gray", 32'(wptr_gray_o), 32'hD);

    // Advance reader to binary 4 (fill 5), one Gray bit per cycle.
    dir_rgray = 4'b0011; step(1'b0);
    dir_rgray = 4'b0010; step(1'b0);
    dir_rgray = 4'b0110; step(1'b0);
    step(1'b0);
    check("simul_pre_fill", 32'(fill_o), 32'd5);
    // Write lands on the same edge the synced read pointer reaches 5.
    dir_rgray = 4'b0111;
    step(1'b0);
    check("simul_mid_fill", 32'(fill_o), 32'd5);
    valid_i = 1'b1;
    exp_q.push_back(3'(pcount));
    pcount++;
    #1;
    check("simul_wr_en", 32'(wr_en_o), 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("simul_fill", 32'(fill_o), 32'd5);
    check("simul_gray", 32'(wptr_gray_o), 32'hF);

    // Wrap: reader follows the write count with a two-cycle lag.
    acc = 0;
    dbin = 5;
    ph0 = int'(pcount);
    ph1 = int'(pcount);
    prev = 4'hF;
    wrap_seen = 1'b0;
    for (int c = 0; c < 400 && acc < 40; c++) begin
      tgt = ph1;
      ph1 = ph0;
      ph0 = int'(pcount);
      if (dbin < tgt) dbin++;
      db4 = 4'(dbin);
      dir_rgray = db4 ^ (db4 >> 1);
      a0 = acc;
      step(1'b1);
      check("wrap_fill_max", 32'(fill_o <= 4'd8), 32'd1);
      if (acc != a0) begin
        cur = wptr_gray_o;
        check("wrap_gray_1bit", 32'($countones(cur ^ prev)), 32'd1);
        if (prev == 4'b1000 && cur == 4'b0000) wrap_seen = 1'b1;
        prev = cur;
      end
    end
    valid_i = 1'b0;
    check("wrap_writes", 32'(acc), 32'd40);
    check("wrap_seen_8_to_0", 32'(wrap_seen), 32'd1);
    check("wrap_final_gray", 32'(wptr_gray_o), 32'b0011);

    // Reset asserted mid-cycle with valid high.
    valid_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(ready_o), 32'd1);
    check("mrst_wr_en", 32'(wr_en_o), 32'd0);
    check("mrst_gray", 32'(wptr_gray_o), 32'd0);
    check("mrst_fill", 32'(fill_o), 32'd0);
    check("mrst_addr", 32'(wr_addr_o), 32'd0);
    exp_q.delete();
    pcount = 0;
    dir_rgray = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_hold_gray", 32'(wptr_gray_o), 32'd0);
    check("mrst_hold_addr", 32'(wr_addr_o), 32'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    step(1'b1);
    valid_i = 1'b0;
    check("mrst_first_gray", 32'(wptr_gray_o), 32'd1);
    check("mrst_first_fill", 32'(fill_o), 32'd1);

    // Asynchronous reader: slower (period 14) then faster (period 6) than the writer.
    run_async(7, 5000);
    run_async(3, 5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
